// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: stage register/flag inputs and the hold/flush controls.
// master = pipeline datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_src1_used;
    logic       id_src2_used;
    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       forward_en;
    logic       branch_taken;
    logic       mem_busy;
    logic       hold_pc;
    logic       hold_if_id;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       hold_back;

    modport master (
        output id_src1, id_src2, id_src1_used, id_src2_used,
        output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        output forward_en, branch_taken, mem_busy,
        input  hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_back
    );

    modport slave (
        input  id_src1, id_src2, id_src1_used, id_src2_used,
        input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        input  forward_en, branch_taken, mem_busy,
        output hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_back
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard/stall/flush controller with optional perf counters (macro HAZARD_PERF_CNT_EN).
// Latency: hold/flush outputs are combinational (zero cycles); state and counters are registered.
// Backpressure: mem_busy freezes the whole pipe; a branch seen during the freeze is flushed once it ends.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_PEND  = 2'd2
    } state_t;

    state_t cur_st;

    logic hz_exe;
    logic hz_mem;
    logic hazard;
    logic hold_pc_c;
    logic hold_if_id_c;
    logic flush_if_id_c;
    logic flush_id_ex_c;
    logic hold_back_c;

    always_comb begin
        hz_exe = hz.exe_wb_en &&
                 ((hz.id_src1_used && (hz.id_src1 == hz.exe_dest)) ||
                  (hz.id_src2_used && (hz.id_src2 == hz.exe_dest)));
        hz_mem = hz.mem_wb_en &&
                 ((hz.id_src1_used && (hz.id_src1 == hz.mem_dest)) ||
                  (hz.id_src2_used && (hz.id_src2 == hz.mem_dest)));
        // With forwarding only a load result is too late to bypass.
        hazard = hz.forward_en ? (hz_exe && hz.exe_mem_r_en) : (hz_exe || hz_mem);
    end

    always_comb begin
        hold_pc_c     = 1'b0;
        hold_if_id_c  = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        hold_back_c   = 1'b0;
        if (!rst) begin
            if (hz.mem_busy) begin
                hold_pc_c    = 1'b1;
                hold_if_id_c = 1'b1;
                hold_back_c  = 1'b1;
            end else if ((cur_st == BR_PEND) || hz.branch_taken) begin
                flush_if_id_c = 1'b1;
                flush_id_ex_c = 1'b1;
            end else if (hazard) begin
                hold_pc_c     = 1'b1;
                hold_if_id_c  = 1'b1;
                flush_id_ex_c = 1'b1;
            end
        end
    end

    assign hz.hold_pc     = hold_pc_c;
    assign hz.hold_if_id  = hold_if_id_c;
    assign hz.flush_if_id = flush_if_id_c;
    assign hz.flush_id_ex = flush_id_ex_c;
    assign hz.hold_back   = hold_back_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st <= RUN;
        end else begin
            case (cur_st)
                RUN, MEM_WAIT: begin
                    if (hz.mem_busy)
                        cur_st <= hz.branch_taken ? BR_PEND : MEM_WAIT;
                    else
                        cur_st <= RUN;
                end
                BR_PEND: begin
                    if (!hz.mem_busy)
                        cur_st <= RUN;
                end
                default: cur_st <= RUN;
            endcase
        end
    end

    assign state = cur_st;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hold_pc_c && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (flush_if_id_c && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors plus a per-cycle reference model.
module tb_pipe_hazard_ctrl;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (hz.slave),
        .state     (state),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: "memory wait seen last cycle" and "branch latched during a wait".
    bit m_wait = 1'b0;
    bit m_br   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pv(input int v);
        return PERF ? v : 0;
    endfunction

    function automatic bit hit(input logic [3:0] src, input logic used, input logic [3:0] dst);
        return used && (src == dst);
    endfunction

    // Expected {hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_back}.
    function automatic logic [4:0] exp_out();
        bit e_hit, m_hit, haz;
        e_hit = hz.exe_wb_en && (hit(hz.id_src1, hz.id_src1_used, hz.exe_dest) ||
                                 hit(hz.id_src2, hz.id_src2_used, hz.exe_dest));
        m_hit = hz.mem_wb_en && (hit(hz.id_src1, hz.id_src1_used, hz.mem_dest) ||
                                 hit(hz.id_src2, hz.id_src2_used, hz.mem_dest));
        haz = hz.forward_en ? (e_hit && hz.exe_mem_r_en) : (e_hit || m_hit);
        if (rst)                          return 5'b00000;
        if (hz.mem_busy)                  return 5'b11001;
        if (m_br || hz.branch_taken)      return 5'b00110;
        if (haz)                          return 5'b11010;
        return 5'b00000;
    endfunction

    always @(posedge clk) begin
        logic [4:0] e;
        e = exp_out();
        if (rst) begin
            m_wait  <= 1'b0;
            m_br    <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_wait <= hz.mem_busy;
            m_br   <= hz.mem_busy && (m_br || hz.branch_taken);
            if (e[4] && m_stall < SAT) m_stall <= m_stall + 1;
            if (e[2] && m_flush < SAT) m_flush <= m_flush + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] e;
            e = exp_out();
            check("mdl_hold_pc",     32'(hz.hold_pc),     32'(e[4]));
            check("mdl_hold_if_id",  32'(hz.hold_if_id),  32'(e[3]));
            check("mdl_flush_if_id", 32'(hz.flush_if_id), 32'(e[2]));
            check("mdl_flush_id_ex", 32'(hz.flush_id_ex), 32'(e[1]));
            check("mdl_hold_back",   32'(hz.hold_back),   32'(e[0]));
            check("mdl_state",       32'(state),          m_br ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
            check("mdl_stall_cnt",   32'(stall_cnt),      32'(pv(m_stall)));
            check("mdl_flush_cnt",   32'(flush_cnt),      32'(pv(m_flush)));
        end
    end

    task automatic idle();
        hz.id_src1 = 4'd0;  hz.id_src2 = 4'd0;
        hz.id_src1_used = 1'b0; hz.id_src2_used = 1'b0;
        hz.exe_dest = 4'd0; hz.exe_wb_en = 1'b0; hz.exe_mem_r_en = 1'b0;
        hz.mem_dest = 4'd0; hz.mem_wb_en = 1'b0;
        hz.forward_en = 1'b1; hz.branch_taken = 1'b0; hz.mem_busy = 1'b0;
    endtask

    task automatic load_use();
        hz.forward_en = 1'b1; hz.exe_mem_r_en = 1'b1; hz.exe_wb_en = 1'b1;
        hz.exe_dest = 4'd3; hz.id_src1 = 4'd3; hz.id_src1_used = 1'b1;
    endtask

    task automatic half();
        @(negedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        load_use();
        hz.mem_busy = 1'b1;
        hz.branch_taken = 1'b1;
        half();
        check("rst_hold_pc",     32'(hz.hold_pc),     32'd0);
        check("rst_flush_if_id", 32'(hz.flush_if_id), 32'd0);
        check("rst_flush_id_ex", 32'(hz.flush_id_ex), 32'd0);
        check("rst_hold_back",   32'(hz.hold_back),   32'd0);
        step();
        chk_en = 1'b1;
        step();
        check("rst_state", 32'(state),     32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_flush", 32'(flush_cnt), 32'd0);

        rst = 1'b0;
        idle();
        step();

        // load-use with forwarding
        load_use();
        half();
        check("lu_hold_pc",     32'(hz.hold_pc),     32'd1);
        check("lu_hold_if_id",  32'(hz.hold_if_id),  32'd1);
        check("lu_flush_id_ex", 32'(hz.flush_id_ex), 32'd1);
        check("lu_flush_if_id", 32'(hz.flush_if_id), 32'd0);
        step();
        check("lu_stall_cnt", 32'(stall_cnt), 32'(pv(1)));

        // plain ALU dependency is forwarded
        hz.exe_mem_r_en = 1'b0;
        half();
        check("fwd_hold_pc",     32'(hz.hold_pc),     32'd0);
        check("fwd_flush_id_ex", 32'(hz.flush_id_ex), 32'd0);
        step();

        // no forwarding: MEM-stage match on src2 stalls
        idle();
        hz.forward_en = 1'b0; hz.mem_wb_en = 1'b1; hz.mem_dest = 4'd5;
        hz.id_src2 = 4'd5; hz.id_src2_used = 1'b1;
        half();
        check("nofwd_hold_pc", 32'(hz.hold_pc), 32'd1);
        step();
        check("nofwd_stall_cnt", 32'(stall_cnt), 32'(pv(2)));
        hz.id_src2_used = 1'b0;
        half();
        check("unused_src_hold_pc", 32'(hz.hold_pc), 32'd0);
        step();

        // branch beats load-use
        idle();
        load_use();
        hz.branch_taken = 1'b1;
        half();
        check("br_flush_if_id", 32'(hz.flush_if_id), 32'd1);
        check("br_flush_id_ex", 32'(hz.flush_id_ex), 32'd1);
        check("br_hold_pc",     32'(hz.hold_pc),     32'd0);
        check("br_hold_if_id",  32'(hz.hold_if_id),  32'd0);
        step();
        check("br_flush_cnt", 32'(flush_cnt), 32'(pv(1)));
        check("br_state",     32'(state),     32'd0);

        // 4-cycle memory wait with a branch in cycle 2
        idle();
        hz.mem_busy = 1'b1;
        half();
        check("mw_hold_back",   32'(hz.hold_back),   32'd1);
        check("mw_hold_pc",     32'(hz.hold_pc),     32'd1);
        check("mw_flush_if_id", 32'(hz.flush_if_id), 32'd0);
        step();
        check("mw_state_c1", 32'(state), 32'd1);
        hz.branch_taken = 1'b1;
        step();
        check("mw_state_c2", 32'(state), 32'd2);
        hz.branch_taken = 1'b0;
        step();
        step();
        check("mw_state_c4", 32'(state), 32'd2);
        hz.mem_busy = 1'b0;
        half();
        check("bp_flush_if_id", 32'(hz.flush_if_id), 32'd1);
        check("bp_flush_id_ex", 32'(hz.flush_id_ex), 32'd1);
        check("bp_hold_pc",     32'(hz.hold_pc),     32'd0);
        step();
        check("bp_state", 32'(state), 32'd0);
        half();
        check("bp_once_flush", 32'(hz.flush_if_id), 32'd0);
        check("bp_stall_cnt", 32'(stall_cnt), 32'(pv(6)));
        check("bp_flush_cnt", 32'(flush_cnt), 32'(pv(2)));
        step();

        // reset while a branch is pending
        hz.mem_busy = 1'b1; hz.branch_taken = 1'b1;
        step();
        check("rbp_state", 32'(state), 32'd2);
        hz.branch_taken = 1'b0;
        rst = 1'b1;
        half();
        check("rbp_hold_pc",   32'(hz.hold_pc),   32'd0);
        check("rbp_hold_back", 32'(hz.hold_back), 32'd0);
        step();
        check("rbp_state_after", 32'(state),     32'd0);
        check("rbp_stall_cnt",   32'(stall_cnt), 32'd0);
        check("rbp_flush_cnt",   32'(flush_cnt), 32'd0);
        rst = 1'b0;
        hz.mem_busy = 1'b0;
        half();
        check("rbp_no_flush", 32'(hz.flush_if_id), 32'd0);
        step();

        // leaving MEM_WAIT into a load-use hazard
        hz.mem_busy = 1'b1;
        step();
        check("mwx_state", 32'(state), 32'd1);
        hz.mem_busy = 1'b0;
        load_use();
        half();
        check("mwx_hold_pc",     32'(hz.hold_pc),     32'd1);
        check("mwx_flush_id_ex", 32'(hz.flush_id_ex), 32'd1);
        check("mwx_hold_back",   32'(hz.hold_back),   32'd0);
        step();
        check("mwx_state_run", 32'(state),     32'd0);
        check("mwx_stall_cnt", 32'(stall_cnt), 32'(pv(2)));

        // sweep of hazard-flag combinations, checked by the model each cycle
        for (int i = 0; i < 64; i++) begin
            idle();
            hz.forward_en   = i[0];
            hz.exe_mem_r_en = i[1];
            hz.exe_wb_en    = i[2];
            hz.mem_wb_en    = i[3];
            hz.id_src1_used = i[4];
            hz.id_src2_used = i[5];
            hz.id_src1  = 4'd7;
            hz.id_src2  = 4'd9;
            hz.exe_dest = i[4] ? 4'd7 : 4'd9;
            hz.mem_dest = i[5] ? 4'd7 : 4'd9;
            step();
        end

        // counter saturation
        idle();
        load_use();
        for (int i = 0; i < 20; i++) step();
        check("sat_stall_cnt", 32'(stall_cnt), 32'(pv(SAT)));
        step();
        check("sat_stall_hold", 32'(stall_cnt), 32'(pv(SAT)));
        idle();
        hz.branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_flush_cnt", 32'(flush_cnt), 32'(pv(SAT)));
        idle();
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the saturating performance counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high, sampled on the rising edge of clk.
REQ-004 SHALL have ports id_src1 and id_src2, input, 4 each: ID-stage source register numbers.
REQ-005 SHALL have ports id_src1_used and id_src2_used, input, 1 each: source is actually read by the ID instruction.
REQ-006 SHALL have ports exe_dest (input, 4), exe_wb_en (input, 1) and exe_mem_r_en (input, 1): EXE-stage destination, writeback enable and load flag.
REQ-007 SHALL have ports mem_dest (input, 4) and mem_wb_en (input, 1): MEM-stage destination and writeback enable.
REQ-008 SHALL have port forward_en, input, 1: forwarding network enabled.
REQ-009 SHALL have port branch_taken, input, 1: EXE stage resolved a taken branch.
REQ-010 SHALL have port mem_busy, input, 1: data memory has not completed the current access.
REQ-011 SHALL have ports hold_pc, hold_if_id, flush_if_id, flush_id_ex and hold_back, output, 1 each; hold_back freezes the ID/EX, EXE/MEM and MEM/WB registers.
REQ-012 SHALL have port state, output, 2: current FSM state; RUN=0, MEM_WAIT=1, BR_PEND=2.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each.

Function
REQ-014 SHALL compute hz_exe as: exe_wb_en, AND a used source equal to exe_dest.
REQ-015 SHALL compute hz_mem as: mem_wb_en, AND a used source equal to mem_dest.
REQ-016 SHALL compute hazard as:
- forward_en=1: hz_exe AND exe_mem_r_en (load-use only).
- forward_en=0: hz_exe OR hz_mem.
REQ-017 In RUN with mem_busy=0 and branch_taken=1:
- flush_if_id=1 and flush_id_ex=1 in the same cycle.
- Hazard is ignored; the state stays RUN.
REQ-018 In RUN with mem_busy=0, branch_taken=0 and hazard=1:
- hold_pc=1, hold_if_id=1 and flush_id_ex=1 (one bubble per hazard cycle).
- The hold is combinational and repeats while hazard persists.
REQ-019 In RUN with mem_busy=1:
- hold_pc, hold_if_id and hold_back all =1; no flush output asserted.
- The next state is MEM_WAIT.
- If branch_taken is also 1, the next state is BR_PEND instead.
REQ-020 In MEM_WAIT:
- All holds stay asserted while mem_busy=1.
- branch_taken=1 in this state moves the next state to BR_PEND.
- mem_busy=0 returns the next state to RUN, with outputs in that cycle per REQ-017/018.
REQ-021 In BR_PEND:
- All holds stay asserted while mem_busy=1.
- On the first cycle with mem_busy=0: flush_if_id=1, flush_id_ex=1, holds=0, and the next state is RUN.
- The flush occurs exactly once per latched branch.
REQ-022 All outputs other than state and counters SHALL be combinational from the inputs and the current state: zero-cycle latency.
REQ-023 flush and hold SHALL never both be asserted on the IF/ID register; flush_if_id has priority.
REQ-024 stall_cnt SHALL increment once per cycle with hold_pc=1, and SHALL saturate at all-ones.
REQ-025 flush_cnt SHALL increment once per cycle with flush_if_id=1, and SHALL saturate at all-ones.

Reset
REQ-026 While rst=1, the state SHALL be RUN on the next edge and both counters SHALL be 0.
REQ-027 While rst=1, all hold and flush outputs SHALL be 0, overriding any input.
REQ-028 Reset mid-MEM_WAIT or mid-BR_PEND SHALL discard any pending branch.

Configuration
REQ-029 The macro HAZARD_PERF_CNT_EN SHALL control the performance counters.
- Defined: counters operate per REQ-024/025.
- Undefined: stall_cnt and flush_cnt are constant 0 and no counter flops exist.

Verification
REQ-030 forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_src1_used=1 -> hold_pc=1, hold_if_id=1 and flush_id_ex=1 for one cycle; stall_cnt becomes 1.
REQ-031 forward_en=1, exe_mem_r_en=0, same register match -> no hold and no flush; forward_en=0 with mem_dest=5 matching id_src2=5 (id_src2_used=1, mem_wb_en=1) -> stall.
REQ-032 branch_taken=1 together with a load-use hazard in RUN -> flush_if_id=1 and flush_id_ex=1, hold_pc=0; flush_cnt becomes 1.
REQ-033 mem_busy=1 for 4 cycles, with branch_taken pulsed in cycle 2 -> state goes 1 then 2, holds asserted 4 cycles, then one flush cycle, then state=0.
REQ-034 rst=1 asserted in BR_PEND -> next cycle state=0 and counters=0; no flush occurs after rst drops.
REQ-035 Force stall_cnt to all-ones, then stall again -> value is unchanged; with HAZARD_PERF_CNT_EN undefined, the counters read 0 throughout.
